// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: the piso_serializer transmitter and the shift_register receiver.
package serial_pkg;

   localparam logic S_IDLE  = 1'b0;
   localparam logic S_SHIFT = 1'b1;

   localparam int SER_WIDTH = 4;

   typedef enum logic {
      IDLE  = S_IDLE,
      SHIFT = S_SHIFT
   } ser_state_e;

endpackage

// File: rtl/shift_register.sv
// Serial-in, parallel-out receiver. It shifts D0 into the LSB, so an MSB-first frame lands in its original order.
module shift_register
   import serial_pkg::*;
#(
   parameter int WIDTH = SER_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             D0,
   input  logic             shift,
   output logic [WIDTH-1:0] Q
);

   logic [WIDTH-1:0] q_d, q_q;

   always_comb begin
      q_d = q_q;
      if (shift) q_d = {q_q[WIDTH-2:0], D0};
   end

   always_ff @(posedge clk) begin
      if (!reset) q_q <= '0;
      else        q_q <= q_d;
   end

   assign Q = q_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter. It accepts a word through a valid/ready handshake and
// emits one bit per unpaused cycle, with a shift_out strobe for the receiver.
//
//   state | meaning
//   IDLE  | waiting for load_valid; load_ready high
//   SHIFT | frame in progress; one bit per cycle unless paused
module piso_serializer
   import serial_pkg::*;
#(
   parameter int WIDTH     = SER_WIDTH,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] data_in,
   input  logic             pause,
   output logic             dout,
   output logic             shift_out,
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   ser_state_e       state_d, state_q;
   logic [WIDTH-1:0] shreg_d, shreg_q;
   logic [CW-1:0]    count_d, count_q;
   logic             dout_d, dout_q;
   logic             shift_out_d, shift_out_q;
   logic             done_d, done_q;

   assign load_ready = (state_q == IDLE) && reset;
   assign busy       = (state_q == SHIFT);

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      count_d     = count_q;
      dout_d      = dout_q;
      shift_out_d = 1'b0;
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_valid && load_ready) begin
               shreg_d = data_in;
               count_d = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (!pause) begin
               dout_d      = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
               shreg_d     = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
               shift_out_d = 1'b1;
               // Last bit clears the counter rather than incrementing, so it never passes WIDTH-1.
               if (count_q == LAST) begin
                  done_d  = 1'b1;
                  count_d = '0;
                  state_d = IDLE;
               end else begin
                  count_d = count_q + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         count_q     <= '0;
         dout_q      <= 1'b0;
         shift_out_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         count_q     <= count_d;
         dout_q      <= dout_d;
         shift_out_q <= shift_out_d;
         done_q      <= done_d;
      end
   end

   assign dout      = dout_q;
   assign shift_out = shift_out_q;
   assign done      = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: piso_serializer looped back into shift_register, 4-bit MSB-first and 8-bit LSB-first.
module tb_piso_serializer;

   logic       clk = 1'b0;
   logic       reset;

   logic       load_valid, load_ready, pause, dout, shift_out, busy, done;
   logic [3:0] data_in, q4;

   logic       load_valid8, load_ready8, pause8, dout8, shift_out8, busy8, done8;
   logic [7:0] data_in8, q8;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) u_tx4 (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
      .data_in(data_in), .pause(pause), .dout(dout), .shift_out(shift_out),
      .busy(busy), .done(done)
   );

   shift_register #(.WIDTH(4)) u_rx4 (
      .clk(clk), .reset(reset), .D0(dout), .shift(shift_out), .Q(q4)
   );

   piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_tx8 (
      .clk(clk), .reset(reset), .load_valid(load_valid8), .load_ready(load_ready8),
      .data_in(data_in8), .pause(pause8), .dout(dout8), .shift_out(shift_out8),
      .busy(busy8), .done(done8)
   );

   shift_register #(.WIDTH(8)) u_rx8 (
      .clk(clk), .reset(reset), .D0(dout8), .shift(shift_out8), .Q(q8)
   );

   // Advance one edge and settle; inputs are driven and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; load_valid = 1'b0; data_in = 4'h0; pause = 1'b0;
      load_valid8 = 1'b0; data_in8 = 8'h00; pause8 = 1'b0;
      tick();
      tick();
      checks++;
      if (load_ready !== 1'b0) begin
         failures++; $display("FAIL reset_ready_low got=%b exp=0", load_ready);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({load_ready, shift_out, dout, done, busy} !== 5'b10000) begin
         failures++;
         $display("FAIL reset_state got ready,sout,dout,done,busy=%b exp=10000",
                  {load_ready, shift_out, dout, done, busy});
      end
      checks++;
      if ({load_ready8, shift_out8, dout8, done8, busy8} !== 5'b10000) begin
         failures++;
         $display("FAIL reset_state8 got=%b exp=10000",
                  {load_ready8, shift_out8, dout8, done8, busy8});
      end
      checks++;
      if (q4 !== 4'h0) begin
         failures++; $display("FAIL reset_q got=%h exp=0", q4);
      end
   endtask

   task automatic test_msb_first();
      logic [3:0] exp_bits;
      exp_bits = 4'b1010;
      data_in = 4'b1010; load_valid = 1'b1;
      tick();
      load_valid = 1'b0; data_in = 4'h0;
      checks++;
      if ({busy, load_ready, shift_out} !== 3'b100) begin
         failures++; $display("FAIL msb_accept got busy,ready,sout=%b exp=100", {busy, load_ready, shift_out});
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if ({dout, shift_out, done} !== {exp_bits[3-k], 1'b1, (k == 3)}) begin
            failures++;
            $display("FAIL msb_bit%0d got dout,sout,done=%b exp=%b", k,
                     {dout, shift_out, done}, {exp_bits[3-k], 1'b1, (k == 3)});
         end
      end
      checks++;
      if (load_ready !== 1'b1) begin
         failures++; $display("FAIL msb_ready_after_last got=%b exp=1", load_ready);
      end
      tick();
      checks++;
      if ({q4, shift_out, done, busy} !== {4'b1010, 3'b000}) begin
         failures++; $display("FAIL msb_loopback got q=%b sout,done,busy=%b exp q=1010 000",
                              q4, {shift_out, done, busy});
      end
   endtask

   task automatic test_pause();
      logic [5:0] exp_dout, exp_sout, exp_done;
      // index 0 is the first cycle after acceptance
      exp_dout = 6'b001111;
      exp_sout = 6'b110011;
      exp_done = 6'b100000;
      data_in = 4'b1100; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++;
         if ({dout, shift_out, done} !== {exp_dout[k], exp_sout[k], exp_done[k]}) begin
            failures++;
            $display("FAIL pause_cycle%0d got dout,sout,done=%b exp=%b", k,
                     {dout, shift_out, done}, {exp_dout[k], exp_sout[k], exp_done[k]});
         end
         pause = (k == 1 || k == 2);
      end
      pause = 1'b0;
      tick();
      checks++;
      if (q4 !== 4'b1100) begin
         failures++; $display("FAIL pause_loopback got=%b exp=1100", q4);
      end
   endtask

   task automatic test_back_to_back();
      data_in = 4'hF; load_valid = 1'b1;
      tick();
      data_in = 4'h0;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if ({dout, shift_out, done} !== {1'b1, 1'b1, (k == 3)}) begin
            failures++;
            $display("FAIL b2b_f_bit%0d got dout,sout,done=%b exp=%b", k,
                     {dout, shift_out, done}, {1'b1, 1'b1, (k == 3)});
         end
         if (k == 2) data_in = 4'h3;
      end
      checks++;
      if (load_ready !== 1'b1) begin
         failures++; $display("FAIL b2b_ready got=%b exp=1", load_ready);
      end
      tick();
      load_valid = 1'b0; data_in = 4'hC;
      checks++;
      if ({shift_out, busy, q4} !== {2'b01, 4'hF}) begin
         failures++; $display("FAIL b2b_gap got sout,busy=%b q=%h exp 01 q=f", {shift_out, busy}, q4);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if ({dout, shift_out, done} !== {(k >= 2), 1'b1, (k == 3)}) begin
            failures++;
            $display("FAIL b2b_3_bit%0d got dout,sout,done=%b exp=%b", k,
                     {dout, shift_out, done}, {(k >= 2), 1'b1, (k == 3)});
         end
      end
      tick();
      checks++;
      if ({q4, shift_out, busy} !== {4'h3, 2'b00}) begin
         failures++; $display("FAIL b2b_loopback got q=%h sout,busy=%b exp q=3 00", q4, {shift_out, busy});
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [3:0] exp_bits;
      data_in = 4'b0110; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      tick();
      tick();
      checks++;
      if ({dout, shift_out, busy} !== 3'b111) begin
         failures++; $display("FAIL midrst_bit1 got dout,sout,busy=%b exp=111", {dout, shift_out, busy});
      end
      reset = 1'b0;
      tick();
      checks++;
      if ({busy, shift_out, done, dout, q4} !== {4'b0000, 4'h0}) begin
         failures++; $display("FAIL midrst_abort got busy,sout,done,dout=%b q=%h exp 0000 q=0",
                              {busy, shift_out, done, dout}, q4);
      end
      reset = 1'b1;
      exp_bits = 4'b1001;
      data_in = 4'b1001; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if ({dout, shift_out, done} !== {exp_bits[3-k], 1'b1, (k == 3)}) begin
            failures++;
            $display("FAIL midrst_resend_bit%0d got dout,sout,done=%b exp=%b", k,
                     {dout, shift_out, done}, {exp_bits[3-k], 1'b1, (k == 3)});
         end
      end
      tick();
      checks++;
      if (q4 !== 4'b1001) begin
         failures++; $display("FAIL midrst_loopback got=%b exp=1001", q4);
      end
   endtask

   task automatic test_lsb_first_wide();
      data_in8 = 8'h01; load_valid8 = 1'b1;
      tick();
      load_valid8 = 1'b0; data_in8 = 8'hFF;
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if ({dout8, shift_out8, done8} !== {(k == 0), 1'b1, (k == 7)}) begin
            failures++;
            $display("FAIL lsb8_bit%0d got dout,sout,done=%b exp=%b", k,
                     {dout8, shift_out8, done8}, {(k == 0), 1'b1, (k == 7)});
         end
         if (k == 3) begin
            load_valid8 = 1'b1;
            checks++;
            if (load_ready8 !== 1'b0) begin
               failures++; $display("FAIL lsb8_ready_midframe got=%b exp=0", load_ready8);
            end
         end
         if (k == 5) load_valid8 = 1'b0;
      end
      tick();
      checks++;
      if ({shift_out8, busy8, done8, q8} !== {3'b000, 8'h80}) begin
         failures++; $display("FAIL lsb8_end got sout,busy,done=%b q=%h exp 000 q=80",
                              {shift_out8, busy8, done8}, q8);
      end
      tick();
      checks++;
      if ({shift_out8, busy8} !== 2'b00) begin
         failures++; $display("FAIL lsb8_no_queue got sout,busy=%b exp=00", {shift_out8, busy8});
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_msb_first();
      test_pause();
      test_back_to_back();
      test_reset_mid_frame();
      test_lsb_first_wide();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
